axi_dma_rd_master: RTL and testbench

AXI4 read master for the DMA read path. It sits directly upstream of the AXI memory slave: it takes one descriptor (start address, byte count), splits it into INCR bursts that never cross 4KB, and issues them on AR with up to MAX_OUTSTANDING bursts in flight. Returned R beats go out on a valid/ready stream toward the DMA write side.

---
 rtl/axi_dma_rd_master.sv | 222 ++++++++++++++++++++++
 tb/tb_axi_dma_rd_master.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_dma_rd_master.sv
// AXI4 read master: splits one (addr, len) descriptor into 4KB-safe INCR bursts and streams the R beats out on dout.
// Latency: first ARVALID two cycles after cmd accept; an R beat reaches dout one cycle after its R handshake; done one cycle after the final dout beat.
// Backpressure: ARs stall at MAX_OUTSTANDING bursts in flight; RREADY drops when the 2-entry skid buffer is full; dout_valid holds until dout_ready.
// Option: define AXI_RD_ID_ROTATE_EN for a per-burst rotating ARID with RID checking (default: ARID=0, RID ignored).
module axi_dma_rd_master #(
    parameter int AXI_ID_WD       = 2,
    parameter int AXI_DATA_WD     = 32,
    parameter int AXI_ADDR_WD     = 32,
    parameter int LEN_WD          = 16,
    parameter int MAX_BURST_LEN   = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   M_AXI_ACLK,
    input  logic                   M_AXI_ARESETN,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [AXI_ADDR_WD-1:0] cmd_addr,
    input  logic [LEN_WD-1:0]      cmd_len,
    output logic                   done,
    output logic                   err,
    output logic [AXI_ADDR_WD-1:0] M_AXI_ARADDR,
    output logic [AXI_ID_WD-1:0]   M_AXI_ARID,
    output logic [1:0]             M_AXI_ARBURST,
    output logic [2:0]             M_AXI_ARSIZE,
    output logic [7:0]             M_AXI_ARLEN,
    output logic                   M_AXI_ARVALID,
    input  logic                   M_AXI_ARREADY,
    input  logic [AXI_DATA_WD-1:0] M_AXI_RDATA,
    input  logic [AXI_ID_WD-1:0]   M_AXI_RID,
    input  logic [1:0]             M_AXI_RRESP,
    input  logic                   M_AXI_RLAST,
    input  logic                   M_AXI_RVALID,
    output logic                   M_AXI_RREADY,
    output logic [AXI_DATA_WD-1:0] dout_data,
    output logic                   dout_last,
    output logic                   dout_valid,
    input  logic                   dout_ready
);

    localparam int DW_BYTE = AXI_DATA_WD / 8;
    localparam int SIZE    = $clog2(DW_BYTE);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                 state;
    logic [AXI_ADDR_WD-1:0] addr_q;       // address of the next burst to present
    logic [LEN_WD-1:0]      rem_q;        // beats not yet presented on AR
    logic [3:0]             outstanding;
    logic [4:0]             outstanding_nxt;
    logic                   err_q;
    logic [12:0]            bytes_to_4k;
    logic [31:0]            beats_to_4k;
    logic [31:0]            burst;
    logic                   ar_fire;
    logic                   r_fire;
    logic                   rlast_fire;
    logic                   ar_can;
    logic                   cmd_misaligned;
    logic                   r_bad;
    logic                   beat_last;

    // skid buffer
    logic [AXI_DATA_WD-1:0] buf_dat [2];
    logic [1:0]             buf_last;
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             count;
    logic [1:0]             count_nxt;
    logic                   dout_fire;

    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARSIZE  = 3'(SIZE);

    assign ar_fire    = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_fire     = M_AXI_RVALID && M_AXI_RREADY;
    assign rlast_fire = r_fire && M_AXI_RLAST;
    assign dout_fire  = dout_valid && dout_ready;

    assign outstanding_nxt = {1'b0, outstanding} + {4'd0, ar_fire} - {4'd0, rlast_fire};
    // a new burst may be presented this cycle if beats remain and the in-flight count after this edge leaves room
    assign ar_can = (state == ISSUE) && (rem_q != '0) && (outstanding_nxt < 5'(MAX_OUTSTANDING));

    assign cmd_misaligned = (cmd_addr[SIZE-1:0] != '0) || (cmd_len[SIZE-1:0] != '0);

    // only the final burst's RLAST can arrive once every burst has been issued and just one is left in flight
    assign beat_last = M_AXI_RLAST && (state == DRAIN) && (outstanding == 4'd1);

`ifdef AXI_RD_ID_ROTATE_EN
    logic [AXI_ID_WD-1:0] next_id;
    logic [AXI_ID_WD-1:0] exp_id;
    assign r_bad = (M_AXI_RRESP != 2'b00) || (M_AXI_RID != exp_id);
`else
    logic unused_rid;
    assign unused_rid   = ^M_AXI_RID;
    assign M_AXI_ARID   = '0;
    assign r_bad        = (M_AXI_RRESP != 2'b00);
`endif

    // burst size: min of remaining beats, max burst length and beats left before the 4KB boundary
    always_comb begin
        bytes_to_4k = 13'h1000 - {1'b0, addr_q[11:0]};
        beats_to_4k = 32'(bytes_to_4k >> SIZE);
        burst       = 32'(rem_q);
        if (burst > 32'(MAX_BURST_LEN)) burst = 32'(MAX_BURST_LEN);
        if (burst > beats_to_4k)        burst = beats_to_4k;
    end

    // descriptor FSM, AR presentation and per-command status
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state         <= IDLE;
            cmd_ready     <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
            err_q         <= 1'b0;
            addr_q        <= '0;
            rem_q         <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARLEN   <= '0;
`ifdef AXI_RD_ID_ROTATE_EN
            M_AXI_ARID    <= '0;
            next_id       <= '0;
            exp_id        <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        err_q <= 1'b0;
`ifdef AXI_RD_ID_ROTATE_EN
                        next_id <= '0;
                        exp_id  <= '0;
`endif
                        if (cmd_misaligned) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else if (cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            addr_q    <= cmd_addr;
                            rem_q     <= cmd_len >> SIZE;
                            cmd_ready <= 1'b0;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // fields are loaded only when AR is idle or firing, so they hold while ARREADY is low
                    if (!M_AXI_ARVALID || M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= ar_can;
                        if (ar_can) begin
                            M_AXI_ARADDR <= addr_q;
                            M_AXI_ARLEN  <= 8'(burst - 32'd1);
                            addr_q       <= addr_q + AXI_ADDR_WD'(burst << SIZE);
                            rem_q        <= rem_q - LEN_WD'(burst);
`ifdef AXI_RD_ID_ROTATE_EN
                            M_AXI_ARID   <= next_id;
                            next_id      <= next_id + AXI_ID_WD'(1);
`endif
                        end
                    end
                    if (ar_fire && (rem_q == '0)) state <= DRAIN;
                end
                DRAIN: begin
                    if ((outstanding == '0) && !dout_valid) begin
                        done      <= 1'b1;
                        err       <= err_q;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (r_fire && r_bad) err_q <= 1'b1;
`ifdef AXI_RD_ID_ROTATE_EN
            if (rlast_fire) exp_id <= exp_id + AXI_ID_WD'(1);
`endif
        end
    end

    // bursts in flight: +1 per AR fire, -1 per RLAST fire
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) outstanding <= '0;
        else                outstanding <= outstanding_nxt[3:0];
    end

    assign count_nxt  = count + {1'b0, r_fire} - {1'b0, dout_fire};
    assign dout_valid = (count != 2'd0);
    assign dout_data  = buf_dat[rd_ptr];
    assign dout_last  = dout_valid && buf_last[rd_ptr];

    // 2-entry skid buffer; RREADY comes from the post-edge occupancy so dout_ready never reaches it combinationally
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            for (int i = 0; i < 2; i++) buf_dat[i] <= '0;
            buf_last     <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
            M_AXI_RREADY <= 1'b0;
        end else begin
            if (r_fire) begin
                buf_dat[wr_ptr]  <= M_AXI_RDATA;
                buf_last[wr_ptr] <= beat_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (dout_fire) rd_ptr <= ~rd_ptr;
            count        <= count_nxt;
            M_AXI_RREADY <= (count_nxt != 2'd2);
        end
    end

`ifndef SYNTHESIS
    // an R beat with no burst in flight is a slave protocol violation
    a_r_without_ar: assert property (@(posedge M_AXI_ACLK) disable iff (!M_AXI_ARESETN)
        (M_AXI_RVALID && M_AXI_RREADY) |-> (outstanding != '0));
`endif

endmodule

// File: tb/tb_axi_dma_rd_master.sv
// Directed bench for axi_dma_rd_master: behavioural AXI read slave, dout sink and hand-computed expectations.
// Latency: n/a (bench).
// Backpressure: slave ARREADY and sink dout_ready are pattern-controlled from the main sequence.
module tb_axi_dma_rd_master;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [15:0] cmd_len  = '0;
    logic        done;
    logic        err;
    logic [31:0] M_AXI_ARADDR;
    logic [1:0]  M_AXI_ARID;
    logic [1:0]  M_AXI_ARBURST;
    logic [2:0]  M_AXI_ARSIZE;
    logic [7:0]  M_AXI_ARLEN;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY = 1'b0;
    logic [31:0] M_AXI_RDATA   = '0;
    logic [1:0]  M_AXI_RID     = '0;
    logic [1:0]  M_AXI_RRESP   = '0;
    logic        M_AXI_RLAST   = 1'b0;
    logic        M_AXI_RVALID  = 1'b0;
    logic        M_AXI_RREADY;
    logic [31:0] dout_data;
    logic        dout_last;
    logic        dout_valid;
    logic        dout_ready = 1'b0;

    always #5 clk = ~clk;

    axi_dma_rd_master dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .done          (done),
        .err           (err),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARID    (M_AXI_ARID),
        .M_AXI_ARBURST (M_AXI_ARBURST),
        .M_AXI_ARSIZE  (M_AXI_ARSIZE),
        .M_AXI_ARLEN   (M_AXI_ARLEN),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RID     (M_AXI_RID),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RLAST   (M_AXI_RLAST),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY),
        .dout_data     (dout_data),
        .dout_last     (dout_last),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  id;
        logic [1:0]  burst;
        logic [2:0]  size;
        int          cyc;
    } ar_t;

    ar_t         ar_log[$];
    ar_t         rq[$];
    logic [31:0] dq_data[$];
    bit          dq_last[$];

    int  n_chk = 0;
    int  n_err = 0;
    int  cyc = 0, occ = 0, rbeat = 0, beat_total = 0, first_rlast_cyc = -1;
    int  n_out = 0, max_out = 0, rr_full_viol = 0, ar_unstable = 0, err_at = -1;
    bit  r_en = 1'b1, tog = 1'b0, ar_slow = 1'b0, ar_pend = 1'b0;
    logic [31:0] pa;
    logic [7:0]  pl;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // AXI read slave and dout sink, all decisions made at the falling edge
    initial begin : slave
        bit  rfire, dfire;
        ar_t rec;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                rq.delete();
                rbeat = 0; n_out = 0; occ = 0; ar_pend = 1'b0;
                M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; M_AXI_ARREADY = 1'b0; dout_ready = 1'b0;
            end else begin
                dout_ready = tog ? cyc[0] : 1'b1;
                if (M_AXI_RREADY && occ >= 2) rr_full_viol++;
                dfire = dout_valid && dout_ready;
                if (dfire) begin
                    dq_data.push_back(dout_data);
                    dq_last.push_back(dout_last);
                end
                rfire = 1'b0;
                if (r_en && rq.size() > 0) begin
                    M_AXI_RVALID = 1'b1;
                    M_AXI_RDATA  = rq[0].addr + 32'(rbeat * 4);
                    M_AXI_RID    = rq[0].id;
                    M_AXI_RLAST  = (rbeat == int'(rq[0].len));
                    M_AXI_RRESP  = (beat_total == err_at) ? 2'b10 : 2'b00;
                    if (M_AXI_RREADY) begin
                        rfire = 1'b1;
                        beat_total++;
                        if (M_AXI_RLAST) begin
                            void'(rq.pop_front());
                            rbeat = 0;
                            n_out--;
                            if (first_rlast_cyc < 0) first_rlast_cyc = cyc;
                        end else begin
                            rbeat++;
                        end
                    end
                end else begin
                    M_AXI_RVALID = 1'b0;
                    M_AXI_RLAST  = 1'b0;
                end
                occ = occ + int'(rfire) - int'(dfire);
                M_AXI_ARREADY = ar_slow ? (cyc % 3 == 0) : 1'b1;
                if (ar_pend && (!M_AXI_ARVALID || M_AXI_ARADDR != pa || M_AXI_ARLEN != pl)) ar_unstable++;
                if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                    rec.addr  = M_AXI_ARADDR;
                    rec.len   = M_AXI_ARLEN;
                    rec.id    = M_AXI_ARID;
                    rec.burst = M_AXI_ARBURST;
                    rec.size  = M_AXI_ARSIZE;
                    rec.cyc   = cyc;
                    ar_log.push_back(rec);
                    rq.push_back(rec);
                    n_out++;
                    if (n_out > max_out) max_out = n_out;
                    ar_pend = 1'b0;
                end else begin
                    ar_pend = M_AXI_ARVALID;
                    pa      = M_AXI_ARADDR;
                    pl      = M_AXI_ARLEN;
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [15:0] l);
        ar_log.delete();
        dq_data.delete();
        dq_last.delete();
        beat_total      = 0;
        first_rlast_cyc = -1;
        @(negedge clk);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max, output logic e);
        int i;
        for (i = 0; i < max; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check({tag, "_done"}, 64'(i < max), 64'd1);
        e = err;
        @(negedge clk);
    endtask

    task automatic check_stream(input string tag, input logic [31:0] a, input int n);
        int bad = 0;
        int nlast = 0;
        int lastpos = -1;
        check({tag, "_beats"}, dq_data.size(), n);
        for (int k = 0; k < dq_data.size(); k++) begin
            if (dq_data[k] !== a + 32'(4 * k)) bad++;
            if (dq_last[k]) begin
                nlast++;
                lastpos = k;
            end
        end
        check({tag, "_data"}, bad, 0);
        check({tag, "_nlast"}, nlast, 1);
        check({tag, "_lastpos"}, lastpos, n - 1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic e;
        int   bad;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_arvalid", M_AXI_ARVALID, 0);
        check("rst_araddr", M_AXI_ARADDR, 0);
        check("rst_arlen", M_AXI_ARLEN, 0);
        check("rst_arid", M_AXI_ARID, 0);
        check("rst_rready", M_AXI_RREADY, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_dout_last", dout_last, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single aligned burst
        issue(32'h1000, 16'd64);
        wait_done("t1", 200, e);
        check("t1_err", e, 0);
        check("t1_nar", ar_log.size(), 1);
        if (ar_log.size() >= 1) begin
            check("t1_araddr", ar_log[0].addr, 32'h1000);
            check("t1_arlen", ar_log[0].len, 15);
            check("t1_arburst", ar_log[0].burst, 1);
            check("t1_arsize", ar_log[0].size, 2);
        end
        check_stream("t1", 32'h1000, 16);

        // 4KB boundary split
        issue(32'h0FF0, 16'd64);
        wait_done("t2", 200, e);
        check("t2_err", e, 0);
        check("t2_nar", ar_log.size(), 2);
        if (ar_log.size() >= 2) begin
            check("t2_addr0", ar_log[0].addr, 32'h0FF0);
            check("t2_len0", ar_log[0].len, 3);
            check("t2_addr1", ar_log[1].addr, 32'h1000);
            check("t2_len1", ar_log[1].len, 11);
        end
        check_stream("t2", 32'h0FF0, 16);

        // outstanding limit with R held off
        r_en = 1'b0;
        issue(32'h2000, 16'd512);
        repeat (30) @(negedge clk);
        check("t3_nar_held", ar_log.size(), 4);
        bad = 0;
        for (int k = 0; k < ar_log.size(); k++)
            if (ar_log[k].addr !== 32'h2000 + 32'(64 * k) || ar_log[k].len !== 8'd15) bad++;
        check("t3_first4", bad, 0);
        check("t3_arvalid_held", M_AXI_ARVALID, 0);
        r_en = 1'b1;
        wait_done("t3", 2000, e);
        check("t3_err", e, 0);
        check("t3_nar", ar_log.size(), 8);
        if (ar_log.size() >= 5) check("t3_5th_after_rlast", 64'(ar_log[4].cyc > first_rlast_cyc), 1);
        check("t3_max_out", max_out, 4);
        check_stream("t3", 32'h2000, 128);

        // dout_ready toggling and ARREADY stalls
        tog = 1'b1;
        ar_slow = 1'b1;
        issue(32'h3000, 16'd64);
        wait_done("t4", 400, e);
        tog = 1'b0;
        ar_slow = 1'b0;
        check("t4_err", e, 0);
        check("t4_nar", ar_log.size(), 1);
        check_stream("t4", 32'h3000, 16);
        check("t4_rready_full", rr_full_viol, 0);
        check("t4_ar_stable", ar_unstable, 0);

        // error response mid-command, then a clean command
        err_at = 5;
        issue(32'h4000, 16'd128);
        wait_done("t5", 400, e);
        err_at = -1;
        check("t5_err", e, 1);
        check_stream("t5", 32'h4000, 32);
        issue(32'h1000, 16'd64);
        wait_done("t5b", 200, e);
        check("t5b_err", e, 0);

        // misaligned and zero-length commands
        issue(32'h1002, 16'd16);
        check("t6_mis_done", done, 1);
        check("t6_mis_err", err, 1);
        check("t6_mis_cmd_ready", cmd_ready, 1);
        repeat (5) @(negedge clk);
        check("t6_mis_nar", ar_log.size(), 0);
        check("t6_mis_arvalid", M_AXI_ARVALID, 0);
        issue(32'h5000, 16'd0);
        check("t6_zero_done", done, 1);
        check("t6_zero_err", err, 0);
        repeat (5) @(negedge clk);
        check("t6_zero_nar", ar_log.size(), 0);

        // reset in the middle of a command
        issue(32'h6000, 16'd256);
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t7_arvalid", M_AXI_ARVALID, 0);
        check("t7_araddr", M_AXI_ARADDR, 0);
        check("t7_rready", M_AXI_RREADY, 0);
        check("t7_dout_valid", dout_valid, 0);
        check("t7_done", done, 0);
        check("t7_cmd_ready", cmd_ready, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        issue(32'h7000, 16'd64);
        wait_done("t7b", 200, e);
        check("t7b_err", e, 0);
        check_stream("t7b", 32'h7000, 16);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
